// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter between the processor memory port
// (master 0, cpu_*) and the host DMA port (master 1, host_*) in front of a
// single downstream memory port. Each master owns one pending slot; exactly
// one downstream transaction is in flight at a time.
//
// Handshake: a master presents a one-cycle read or write strobe with address
// and data. The strobe is accepted only while that master's busy is low, and
// busy rises on the following cycle. Busy stays high until the transaction
// completes, so a master with busy high must not strobe. Downstream, a
// one-cycle memory_*_req is followed by memory_busy rising and then falling.
// The fall marks completion. If memory_busy never rises, the transaction is
// forced complete after BUSY_TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int BUSY_TIMEOUT = 16,
  parameter int ADDR_W       = 26
) (
  input  logic              clk,
  input  logic              reset,
  // master 0: processor port
  input  logic              cpu_read_req,
  input  logic              cpu_write_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_data_write,
  output logic [31:0]       cpu_data_read,
  output logic              cpu_busy,
  // master 1: host DMA port
  input  logic              host_read_req,
  input  logic              host_write_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_data_write,
  output logic [31:0]       host_data_read,
  output logic              host_busy,
  // downstream memory port
  output logic              memory_read_req,
  output logic              memory_write_req,
  output logic [ADDR_W-1:0] memory_addr,
  output logic [31:0]       memory_data_write,
  input  logic [31:0]       memory_data_read,
  input  logic              memory_busy,
  // debug readout
  output logic [1:0]        err_sticky,
  output logic              timeout_sticky,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam int               CNT_W    = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  // FSM and arbitration state
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_grant;
  logic              w_grant_nxt;
  logic              r_last_grant;
  logic [CNT_W-1:0]  r_cnt;

  // per-master pending slots, indexed by master number
  logic [1:0]        r_slot_valid;
  logic [1:0]        r_slot_we;
  logic [ADDR_W-1:0] r_slot_addr  [2];
  logic [31:0]       r_slot_wdata [2];
  logic [31:0]       r_data_read  [2];

  // downstream address/data registers, held between issues
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  // sticky debug flags
  logic [1:0]        r_err;
  logic              r_timeout;

  // master request bundles, indexed by master number
  logic [1:0]        w_rd;
  logic [1:0]        w_wr;
  logic [ADDR_W-1:0] w_addr  [2];
  logic [31:0]       w_wdata [2];

  // FSM decode
  logic              w_grant_load;
  logic              w_issue;
  logic              w_complete;
  logic              w_timeout;
  logic              w_cnt_inc;

  assign w_rd       = {host_read_req, cpu_read_req};
  assign w_wr       = {host_write_req, cpu_write_req};
  assign w_addr[0]  = cpu_addr;
  assign w_addr[1]  = host_addr;
  assign w_wdata[0] = cpu_data_write;
  assign w_wdata[1] = host_data_write;

  // Next-state, grant selection and completion decode
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_grant_load = 1'b0;
    w_issue      = 1'b0;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|r_slot_valid) begin
          w_grant_load = 1'b1;
          // a tie goes to the master that was not served last; otherwise
          // the single valid slot wins
          if (&r_slot_valid) begin
            w_grant_nxt = ~r_last_grant;
          end else begin
            w_grant_nxt = r_slot_valid[1];
          end
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (memory_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_complete  = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!memory_busy) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, grant, wait counter and downstream address/data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_load) begin
        r_grant    <= w_grant_nxt;
        r_mem_addr <= r_slot_addr[w_grant_nxt];
        // reads leave the write-data bus at its last written value
        if (r_slot_we[w_grant_nxt]) begin
          r_mem_wdata <= r_slot_wdata[w_grant_nxt];
        end
      end
      if (w_issue) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_complete) begin
        r_last_grant <= r_grant;
      end
    end
  end

  // Pending slots: load on an accepted strobe, clear on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_valid <= '0;
      r_slot_we    <= '0;
      for (int m = 0; m < 2; m++) begin
        r_slot_addr[m]  <= '0;
        r_slot_wdata[m] <= '0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (w_complete && (r_grant == 1'(m))) begin
          r_slot_valid[m] <= 1'b0;
        end else if ((w_rd[m] || w_wr[m]) && !r_slot_valid[m]) begin
          // read and write together keeps the write
          r_slot_valid[m] <= 1'b1;
          r_slot_we[m]    <= w_wr[m];
          r_slot_addr[m]  <= w_addr[m];
          r_slot_wdata[m] <= w_wdata[m];
        end
      end
    end
  end

  // Read-data capture for the granted master on read completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_read[0] <= '0;
      r_data_read[1] <= '0;
    end else if (w_complete && !r_slot_we[r_grant]) begin
      r_data_read[r_grant] <= memory_data_read;
    end
  end

  // Sticky error and timeout flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err     <= '0;
      r_timeout <= 1'b0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (w_rd[m] && w_wr[m]) begin
          r_err[1] <= 1'b1;
        end
        if ((w_rd[m] || w_wr[m]) && r_slot_valid[m]) begin
          r_err[0] <= 1'b1;
        end
      end
      if (w_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign cpu_data_read     = r_data_read[0];
  assign host_data_read    = r_data_read[1];
  assign cpu_busy          = r_slot_valid[0];
  assign host_busy         = r_slot_valid[1];
  assign memory_read_req   = w_issue && !r_slot_we[r_grant];
  assign memory_write_req  = w_issue && r_slot_we[r_grant];
  assign memory_addr       = r_mem_addr;
  assign memory_data_write = r_mem_wdata;
  assign err_sticky        = r_err;
  assign timeout_sticky    = r_timeout;
  assign dbg_state         = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a downstream responder with a memory model,
// directed scenario tasks, and a round-robin scoreboard for mixed traffic.
module tb_mem_port_arbiter;
  localparam int AW = 26;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          cpu_read_req = 0, cpu_write_req = 0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_data_write = '0;
  logic [31:0]   cpu_data_read;
  logic          cpu_busy;
  logic          host_read_req = 0, host_write_req = 0;
  logic [AW-1:0] host_addr = '0;
  logic [31:0]   host_data_write = '0;
  logic [31:0]   host_data_read;
  logic          host_busy;
  logic          memory_read_req, memory_write_req;
  logic [AW-1:0] memory_addr;
  logic [31:0]   memory_data_write;
  logic [31:0]   memory_data_read = '0;
  logic          memory_busy = 1'b0;
  logic [1:0]    err_sticky;
  logic          timeout_sticky;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.BUSY_TIMEOUT(16), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_read_req(cpu_read_req), .cpu_write_req(cpu_write_req),
    .cpu_addr(cpu_addr), .cpu_data_write(cpu_data_write),
    .cpu_data_read(cpu_data_read), .cpu_busy(cpu_busy),
    .host_read_req(host_read_req), .host_write_req(host_write_req),
    .host_addr(host_addr), .host_data_write(host_data_write),
    .host_data_read(host_data_read), .host_busy(host_busy),
    .memory_read_req(memory_read_req), .memory_write_req(memory_write_req),
    .memory_addr(memory_addr), .memory_data_write(memory_data_write),
    .memory_data_read(memory_data_read), .memory_busy(memory_busy),
    .err_sticky(err_sticky), .timeout_sticky(timeout_sticky),
    .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  // downstream responder state and memory model
  logic [31:0]   mem [int];
  int            rsp_delay = 2;
  bit            rsp_noresp = 0;
  int            rsp_left = 0;
  bit            prev_req = 0;
  bit            rsp_seen = 0;
  int            req_cnt = 0;
  bit            last_we = 0;
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   last_wdata = '0;

  // scoreboard for mixed traffic
  logic [31:0] exp_q_cpu[$];
  logic [31:0] exp_q_host[$];

  function automatic logic [31:0] mem_rd(input int a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Downstream memory: answers each strobe with rsp_delay cycles of busy
  task automatic resp_tick();
    bit req;
    req = memory_read_req | memory_write_req;
    rsp_seen = req;
    if (req) begin
      n_tests++;
      if (prev_req || rsp_left != 0 || (memory_read_req && memory_write_req)) begin
        n_fail++;
        $display("FAIL downstream_protocol: cyc %0d rd=%0b wr=%0b prev_req=%0b busy_left=%0d, required one isolated strobe",
                 cyc, memory_read_req, memory_write_req, prev_req, rsp_left);
      end
      req_cnt++;
      last_we = memory_write_req;
      last_addr = memory_addr;
      last_wdata = memory_data_write;
      if (memory_write_req) mem[int'(memory_addr)] = memory_data_write;
      else memory_data_read = mem_rd(int'(memory_addr));
      rsp_left = rsp_noresp ? 0 : rsp_delay;
      memory_busy = 1'b0;
    end else if (rsp_left > 0) begin
      memory_busy = 1'b1;
      rsp_left--;
    end else begin
      memory_busy = 1'b0;
    end
    prev_req = req;
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
    cyc++;
    resp_tick();
  endtask

  task automatic clear_strobes();
    cpu_read_req = 0; cpu_write_req = 0;
    host_read_req = 0; host_write_req = 0;
  endtask

  task automatic strobe(input bit m, input bit rd, input bit wr,
                        input logic [AW-1:0] a, input logic [31:0] d);
    if (!m) begin
      cpu_read_req = rd; cpu_write_req = wr; cpu_addr = a; cpu_data_write = d;
    end else begin
      host_read_req = rd; host_write_req = wr; host_addr = a; host_data_write = d;
    end
  endtask

  task automatic pulse(input bit m, input bit rd, input bit wr,
                       input logic [AW-1:0] a, input logic [31:0] d);
    strobe(m, rd, wr, a, d);
    tick();
    clear_strobes();
  endtask

  task automatic do_reset();
    clear_strobes();
    reset = 1;
    tick();
    tick();
    reset = 0;
    rsp_left = 0;
    memory_busy = 0;
    prev_req = 0;
    rsp_noresp = 0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (rsp_seen) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (!cpu_busy && !host_busy && dbg_state == 2'd0) begin
        ok = 1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    n_tests++; if ({cpu_busy, host_busy} !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b expected 00", {cpu_busy, host_busy}); end
    n_tests++; if ({memory_read_req, memory_write_req} !== 2'b00) begin n_fail++; $display("FAIL reset_req: got %b expected 00", {memory_read_req, memory_write_req}); end
    n_tests++; if (cpu_data_read !== 32'h0 || host_data_read !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h/%h expected 0/0", cpu_data_read, host_data_read); end
    n_tests++; if (memory_addr !== '0 || memory_data_write !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", memory_addr, memory_data_write); end
    n_tests++; if ({err_sticky, timeout_sticky} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {err_sticky, timeout_sticky}); end
  endtask

  task automatic test_single_read();
    do_reset();
    mem[32'h100] = 32'hDEADBEEF;
    rsp_delay = 3;
    pulse(0, 1, 0, 26'h100, 32'h0);
    n_tests++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise: got %b expected 1", cpu_busy); end
    n_tests++; if (memory_read_req !== 1'b0) begin n_fail++; $display("FAIL single_no_early_req: got %b expected 0", memory_read_req); end
    tick();
    n_tests++; if ({memory_read_req, memory_write_req} !== 2'b10) begin n_fail++; $display("FAIL single_issue: got rd/wr %b expected 10", {memory_read_req, memory_write_req}); end
    n_tests++; if (memory_addr !== 26'h100) begin n_fail++; $display("FAIL single_addr: got %h expected 100", memory_addr); end
    repeat (4) tick();
    n_tests++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_at_completion: got %b expected 1", cpu_busy); end
    tick();
    n_tests++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b expected 0", cpu_busy); end
    n_tests++; if (cpu_data_read !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h expected deadbeef", cpu_data_read); end
    n_tests++; if (host_busy !== 1'b0 || host_data_read !== 32'h0) begin n_fail++; $display("FAIL single_host_untouched: got %b/%h expected 0/0", host_busy, host_data_read); end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    mem[32'h30] = 32'hCAFE0030;
    rsp_delay = 1;
    strobe(0, 0, 1, 26'h20, 32'h11111111);
    strobe(1, 1, 0, 26'h30, 32'h0);
    tick();
    clear_strobes();
    tick();
    n_tests++; if ({memory_write_req, memory_read_req} !== 2'b10) begin n_fail++; $display("FAIL rr_first_op: got wr/rd %b expected 10", {memory_write_req, memory_read_req}); end
    n_tests++; if (memory_addr !== 26'h20 || memory_data_write !== 32'h11111111) begin n_fail++; $display("FAIL rr_first_addr: got %h/%h expected 20/11111111", memory_addr, memory_data_write); end
    repeat (4) tick();
    n_tests++; if ({memory_write_req, memory_read_req} !== 2'b01) begin n_fail++; $display("FAIL rr_second_op: got wr/rd %b expected 01", {memory_write_req, memory_read_req}); end
    n_tests++; if (memory_addr !== 26'h30) begin n_fail++; $display("FAIL rr_second_addr: got %h expected 30", memory_addr); end
    repeat (3) tick();
    n_tests++; if (host_busy !== 1'b0 || host_data_read !== 32'hCAFE0030) begin n_fail++; $display("FAIL rr_host_data: got %b/%h expected 0/cafe0030", host_busy, host_data_read); end
    n_tests++; if (cpu_data_read !== 32'h0) begin n_fail++; $display("FAIL rr_write_no_data: got %h expected 0", cpu_data_read); end
    // lone CPU read: CPU becomes last served
    pulse(0, 1, 0, 26'h20, 32'h0);
    wait_idle(ok);
    n_tests++; if (!ok || cpu_data_read !== 32'h11111111) begin n_fail++; $display("FAIL rr_readback: got ok=%b %h expected 11111111", ok, cpu_data_read); end
    // next tie must go to the host
    strobe(0, 1, 0, 26'h30, 32'h0);
    strobe(1, 0, 1, 26'h20, 32'h22222222);
    tick();
    clear_strobes();
    wait_req(ok);
    n_tests++; if (!ok || last_we !== 1'b1 || last_addr !== 26'h20 || last_wdata !== 32'h22222222) begin n_fail++; $display("FAIL rr_swap_first: got ok=%b we=%b addr=%h data=%h expected host write 20", ok, last_we, last_addr, last_wdata); end
    wait_req(ok);
    n_tests++; if (!ok || last_we !== 1'b0 || last_addr !== 26'h30) begin n_fail++; $display("FAIL rr_swap_second: got ok=%b we=%b addr=%h expected cpu read 30", ok, last_we, last_addr); end
    wait_idle(ok);
    n_tests++; if (!ok || cpu_data_read !== 32'hCAFE0030) begin n_fail++; $display("FAIL rr_swap_data: got ok=%b %h expected cafe0030", ok, cpu_data_read); end
  endtask

  task automatic test_errors();
    bit ok;
    int c0;
    do_reset();
    rsp_delay = 2;
    c0 = req_cnt;
    pulse(0, 0, 1, 26'h40, 32'h0000000A);
    n_tests++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL err_busy: got %b expected 1", cpu_busy); end
    pulse(0, 0, 1, 26'h44, 32'h0000000B);
    wait_idle(ok);
    n_tests++; if (!ok || req_cnt - c0 !== 1 || last_addr !== 26'h40) begin n_fail++; $display("FAIL err_ignored_strobe: got ok=%b strobes=%0d addr=%h expected 1 strobe to 40", ok, req_cnt - c0, last_addr); end
    n_tests++; if (err_sticky !== 2'b01) begin n_fail++; $display("FAIL err_busy_flag: got %b expected 01", err_sticky); end
    pulse(0, 1, 1, 26'h50, 32'h00000055);
    wait_req(ok);
    n_tests++; if (!ok || {memory_write_req, memory_read_req} !== 2'b10 || memory_addr !== 26'h50) begin n_fail++; $display("FAIL err_rw_keeps_write: got ok=%b wr/rd=%b addr=%h expected 10 at 50", ok, {memory_write_req, memory_read_req}, memory_addr); end
    n_tests++; if (err_sticky !== 2'b11) begin n_fail++; $display("FAIL err_rw_flag: got %b expected 11", err_sticky); end
    // strobe exactly on the completion cycle is ignored
    repeat (3) tick();
    n_tests++; if (cpu_busy !== 1'b1) begin n_fail++; $display("FAIL err_busy_at_completion: got %b expected 1", cpu_busy); end
    pulse(0, 1, 0, 26'h60, 32'h0);
    n_tests++; if (cpu_busy !== 1'b0) begin n_fail++; $display("FAIL err_completion_strobe_busy: got %b expected 0", cpu_busy); end
    c0 = req_cnt;
    repeat (4) tick();
    n_tests++; if (req_cnt !== c0) begin n_fail++; $display("FAIL err_completion_strobe_req: got %0d extra strobes expected 0", req_cnt - c0); end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    rsp_noresp = 1;
    mem[32'h70] = 32'h70707070;
    pulse(0, 1, 0, 26'h70, 32'h0);
    wait_req(ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL to_issue: got no strobe expected one"); end
    repeat (16) tick();
    n_tests++; if (cpu_busy !== 1'b1 || timeout_sticky !== 1'b0) begin n_fail++; $display("FAIL to_before: got busy=%b to=%b expected 1/0", cpu_busy, timeout_sticky); end
    tick();
    n_tests++; if (cpu_busy !== 1'b0 || timeout_sticky !== 1'b1) begin n_fail++; $display("FAIL to_after: got busy=%b to=%b expected 0/1", cpu_busy, timeout_sticky); end
    n_tests++; if (cpu_data_read !== 32'h70707070 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL to_data: got %h state=%0d expected 70707070/0", cpu_data_read, dbg_state); end
    rsp_noresp = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    rsp_delay = 10;
    pulse(1, 1, 0, 26'h30, 32'h0);
    wait_req(ok);
    repeat (3) tick();
    n_tests++; if (!ok || dbg_state !== 2'd3) begin n_fail++; $display("FAIL rm_wait_done: got ok=%b state=%0d expected 3", ok, dbg_state); end
    reset = 1;
    tick();
    reset = 0;
    n_tests++; if ({cpu_busy, host_busy} !== 2'b00 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL rm_cleared: got busy=%b state=%0d expected 00/0", {cpu_busy, host_busy}, dbg_state); end
    n_tests++; if ({err_sticky, timeout_sticky} !== 3'b000) begin n_fail++; $display("FAIL rm_flags: got %b expected 000", {err_sticky, timeout_sticky}); end
    n_tests++; if (cpu_data_read !== 32'h0 || host_data_read !== 32'h0) begin n_fail++; $display("FAIL rm_data: got %h/%h expected 0/0", cpu_data_read, host_data_read); end
    rsp_left = 0;
    memory_busy = 0;
    prev_req = 0;
    rsp_delay = 2;
    pulse(1, 1, 0, 26'h30, 32'h0);
    wait_idle(ok);
    n_tests++; if (!ok || host_data_read !== 32'hCAFE0030) begin n_fail++; $display("FAIL rm_recover: got ok=%b %h expected cafe0030", ok, host_data_read); end
  endtask

  task automatic test_back_to_back();
    bit pend[2], iss[2], pwe[2];
    logic [AW-1:0] paddr[2];
    logic [31:0] pdat[2];
    int pcyc[2];
    int started, done, budget, c0, m;
    bit rr, e0, e1, rd, busy_m;
    logic [31:0] exp_d, got_d;
    do_reset();
    pend = '{0, 0}; iss = '{0, 0};
    started = 0; done = 0; budget = 0; rr = 1;
    c0 = req_cnt;
    exp_q_cpu.delete();
    exp_q_host.delete();
    while (done < 1000 && budget < 40000) begin
      tick();
      budget++;
      if (rsp_seen) begin
        e0 = pend[0] && !iss[0] && (pcyc[0] <= cyc - 2);
        e1 = pend[1] && !iss[1] && (pcyc[1] <= cyc - 2);
        n_tests++;
        if (!e0 && !e1) begin
          n_fail++;
          $display("FAIL b2b_spurious_strobe: cyc %0d addr %h with no eligible pending request", cyc, last_addr);
        end else begin
          m = (e0 && e1) ? int'(!rr) : int'(e1);
          if (last_we !== pwe[m] || last_addr !== paddr[m] || (pwe[m] && last_wdata !== pdat[m])) begin
            n_fail++;
            $display("FAIL b2b_order: cyc %0d got we=%b addr=%h data=%h expected master %0d we=%b addr=%h data=%h",
                     cyc, last_we, last_addr, last_wdata, m, pwe[m], paddr[m], pdat[m]);
          end
          iss[m] = 1;
          rr = m[0];
          if (!pwe[m]) begin
            if (m == 0) exp_q_cpu.push_back(mem_rd(int'(paddr[m])));
            else exp_q_host.push_back(mem_rd(int'(paddr[m])));
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        busy_m = (k == 0) ? cpu_busy : host_busy;
        if (pend[k] && iss[k] && !busy_m) begin
          done++;
          if (!pwe[k]) begin
            got_d = (k == 0) ? cpu_data_read : host_data_read;
            exp_d = 32'h0;
            if (k == 0 && exp_q_cpu.size() > 0) exp_d = exp_q_cpu.pop_front();
            if (k == 1 && exp_q_host.size() > 0) exp_d = exp_q_host.pop_front();
            n_tests++;
            if (got_d !== exp_d) begin
              n_fail++;
              $display("FAIL b2b_read_data: master %0d addr %h got %h expected %h", k, paddr[k], got_d, exp_d);
            end
          end
          pend[k] = 0;
          iss[k] = 0;
        end else if (pend[k] && !iss[k] && !busy_m && cyc > pcyc[k]) begin
          n_tests++;
          n_fail++;
          $display("FAIL b2b_lost_request: master %0d addr %h busy low before issue", k, paddr[k]);
          pend[k] = 0;
        end
      end
      clear_strobes();
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && started < 1000 && $urandom_range(0, 2) != 0) begin
          rd = ($urandom_range(0, 1) == 1);
          pwe[k] = !rd;
          paddr[k] = AW'($urandom_range(0, 7) * 4);
          pdat[k] = $urandom;
          strobe(k[0], rd, !rd, paddr[k], pdat[k]);
          pend[k] = 1;
          iss[k] = 0;
          pcyc[k] = cyc;
          started++;
        end
      end
      rsp_delay = $urandom_range(1, 4);
    end
    clear_strobes();
    n_tests++; if (done != 1000) begin n_fail++; $display("FAIL b2b_complete: got %0d completions expected 1000", done); end
    n_tests++; if (req_cnt - c0 != 1000) begin n_fail++; $display("FAIL b2b_strobe_count: got %0d expected 1000", req_cnt - c0); end
    n_tests++; if ({err_sticky, timeout_sticky} !== 3'b000) begin n_fail++; $display("FAIL b2b_flags: got %b expected 000", {err_sticky, timeout_sticky}); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
